// File: rtl/pipeline_pkg.sv
// pipeline_pkg: control-bundle layout and bubble constant shared by the ID/EX stage
package pipeline_pkg;
    localparam int CTRL_W        = 9;
    localparam int CTRL_REGWRITE = 8;
    localparam int CTRL_MEMREAD  = 7;
    localparam int CTRL_MEMWRITE = 6;
    localparam int CTRL_MEMTOREG = 5;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_REGDST   = 3;
    localparam int CTRL_ALUOP    = 0;
    localparam logic [CTRL_W-1:0] BUBBLE = '0;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use detection and PC / IF-ID write enables
module hazard_detect (
    input  logic       i_ex_valid,
    input  logic       i_ex_memread,
    input  logic [4:0] i_ex_rt,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_uses_rt,
    input  logic       i_id_valid,
    input  logic       i_flush,
    input  logic       i_hold,
    output logic       o_stall,
    output logic       o_pc_write,
    output logic       o_if_id_write
);
    logic w_lu;

    // a load into $0 never produces a value worth waiting for
    assign w_lu = i_ex_valid & i_ex_memread & (i_ex_rt != 5'd0) & i_id_valid &
                  ((i_ex_rt == i_id_rs) | (i_id_uses_rt & (i_ex_rt == i_id_rt)));
    // a flush discards the ID consumer, so there is nothing to stall for
    assign o_stall       = w_lu & ~i_flush & ~i_hold;
    assign o_pc_write    = ~o_stall & ~i_hold;
    assign o_if_id_write = ~o_stall & ~i_hold;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubbles, flush bubbles and perf counters
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              flush,
    input  logic [4:0]        IF_ID_Rs,
    input  logic [4:0]        IF_ID_Rt,
    input  logic [4:0]        IF_ID_Rd,
    input  logic              IF_ID_UsesRt,
    input  logic              IF_ID_Valid,
    input  logic [CTRL_W-1:0] ID_Ctrl,
    input  logic [DATA_W-1:0] ID_Data1,
    input  logic [DATA_W-1:0] ID_Data2,
    input  logic [DATA_W-1:0] ID_Imm,
    input  logic [DATA_W-1:0] ID_PC4,
    output logic [4:0]        ID_EX_Rs,
    output logic [4:0]        ID_EX_Rt,
    output logic [4:0]        ID_EX_Rd,
    output logic [CTRL_W-1:0] ID_EX_Ctrl,
    output logic [DATA_W-1:0] ID_EX_Data1,
    output logic [DATA_W-1:0] ID_EX_Data2,
    output logic [DATA_W-1:0] ID_EX_Imm,
    output logic [DATA_W-1:0] ID_EX_PC4,
    output logic              ID_EX_Valid,
    output logic              PCWrite,
    output logic              IF_ID_Write,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    logic              w_stall;
    logic              w_bubble;
    logic [4:0]        r_rs, r_rt, r_rd;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data1, r_data2, r_imm, r_pc4;
    logic              r_valid;
    logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;

    hazard_detect u_hazard (
        .i_ex_valid    (r_valid),
        .i_ex_memread  (r_ctrl[CTRL_MEMREAD]),
        .i_ex_rt       (r_rt),
        .i_id_rs       (IF_ID_Rs),
        .i_id_rt       (IF_ID_Rt),
        .i_id_uses_rt  (IF_ID_UsesRt),
        .i_id_valid    (IF_ID_Valid),
        .i_flush       (flush),
        .i_hold        (hold),
        .o_stall       (w_stall),
        .o_pc_write    (PCWrite),
        .o_if_id_write (IF_ID_Write)
    );

    // zeroed register numbers keep the forwarding unit from matching a bubble
    assign w_bubble = flush | w_stall;

    // pipeline register: hold freezes everything, flush/stall insert a bubble, else load from ID
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_ctrl      <= BUBBLE;
            r_data1     <= '0;
            r_data2     <= '0;
            r_imm       <= '0;
            r_pc4       <= '0;
            r_valid     <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!hold) begin
            r_rs        <= w_bubble ? 5'd0 : IF_ID_Rs;
            r_rt        <= w_bubble ? 5'd0 : IF_ID_Rt;
            r_rd        <= w_bubble ? 5'd0 : IF_ID_Rd;
            r_ctrl      <= (w_bubble | ~IF_ID_Valid) ? BUBBLE : ID_Ctrl;
            r_valid     <= ~w_bubble & IF_ID_Valid;
            r_data1     <= ID_Data1;
            r_data2     <= ID_Data2;
            r_imm       <= ID_Imm;
            r_pc4       <= ID_PC4;
            if (w_stall && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (flush && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign ID_EX_Rs    = r_rs;
    assign ID_EX_Rt    = r_rt;
    assign ID_EX_Rd    = r_rd;
    assign ID_EX_Ctrl  = r_ctrl;
    assign ID_EX_Data1 = r_data1;
    assign ID_EX_Data2 = r_data2;
    assign ID_EX_Imm   = r_imm;
    assign ID_EX_PC4   = r_pc4;
    assign ID_EX_Valid = r_valid;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of ID/EX loading, load-use stalls, flush, hold and saturation
module tb_id_ex_stage;
    localparam logic [8:0] C_ADD  = 9'h10A;
    localparam logic [8:0] C_LW   = 9'h1B0;
    localparam logic [8:0] C_ADDI = 9'h110;

    logic        clk, reset, hold, flush;
    logic [4:0]  if_rs, if_rt, if_rd;
    logic        uses_rt, if_valid;
    logic [8:0]  id_ctrl;
    logic [31:0] d1, d2, imm, pc4;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [8:0]  ex_ctrl;
    logic [31:0] ex_d1, ex_d2, ex_imm, ex_pc4;
    logic        ex_valid, pc_write, ifid_write;
    logic [15:0] stall_cnt, flush_cnt;
    logic [4:0]  s_rs, s_rt, s_rd;
    logic [8:0]  s_ctrl;
    logic [31:0] s_d1, s_d2, s_imm, s_pc4;
    logic        s_valid, s_pcw, s_ifw;
    logic [2:0]  s_stall_cnt, s_flush_cnt;
    int checks = 0;
    int errors = 0;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush),
        .IF_ID_Rs(if_rs), .IF_ID_Rt(if_rt), .IF_ID_Rd(if_rd),
        .IF_ID_UsesRt(uses_rt), .IF_ID_Valid(if_valid), .ID_Ctrl(id_ctrl),
        .ID_Data1(d1), .ID_Data2(d2), .ID_Imm(imm), .ID_PC4(pc4),
        .ID_EX_Rs(ex_rs), .ID_EX_Rt(ex_rt), .ID_EX_Rd(ex_rd), .ID_EX_Ctrl(ex_ctrl),
        .ID_EX_Data1(ex_d1), .ID_EX_Data2(ex_d2), .ID_EX_Imm(ex_imm), .ID_EX_PC4(ex_pc4),
        .ID_EX_Valid(ex_valid), .PCWrite(pc_write), .IF_ID_Write(ifid_write),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    id_ex_stage #(.DATA_W(32), .CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush),
        .IF_ID_Rs(if_rs), .IF_ID_Rt(if_rt), .IF_ID_Rd(if_rd),
        .IF_ID_UsesRt(uses_rt), .IF_ID_Valid(if_valid), .ID_Ctrl(id_ctrl),
        .ID_Data1(d1), .ID_Data2(d2), .ID_Imm(imm), .ID_PC4(pc4),
        .ID_EX_Rs(s_rs), .ID_EX_Rt(s_rt), .ID_EX_Rd(s_rd), .ID_EX_Ctrl(s_ctrl),
        .ID_EX_Data1(s_d1), .ID_EX_Data2(s_d2), .ID_EX_Imm(s_imm), .ID_EX_PC4(s_pc4),
        .ID_EX_Valid(s_valid), .PCWrite(s_pcw), .IF_ID_Write(s_ifw),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // drive inputs 2 ns after a rising edge, away from the sampling edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic ur, input logic v, input logic [8:0] c);
        if_rs = rs; if_rt = rt; if_rd = rd; uses_rt = ur; if_valid = v; id_ctrl = c;
        d1 = 32'hA000_0000 | 32'(rs); d2 = 32'hB000_0000 | 32'(rt);
        imm = 32'h0000_0004; pc4 = 32'h0000_1000 | 32'(rd);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; hold = 1'b0; flush = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 9'h0);
        tick();
        checks++; if (ex_ctrl !== 9'h0) begin errors++; $display("FAIL reset_ctrl: got %h want 000", ex_ctrl); end
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ex_valid); end
        checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %h/%h want 0/0", stall_cnt, flush_cnt); end
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL reset_pcwrite: got %b want 1", pc_write); end
        reset = 1'b1;
    endtask

    task automatic test_load();
        drive(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, C_ADD);
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL add_pcwrite: got %b want 1", pc_write); end
        tick();
        checks++; if ({ex_rs, ex_rt, ex_rd} !== {5'd1, 5'd2, 5'd3}) begin errors++; $display("FAIL add_regs: got %0d/%0d/%0d want 1/2/3", ex_rs, ex_rt, ex_rd); end
        checks++; if (ex_ctrl !== C_ADD || ex_valid !== 1'b1) begin errors++; $display("FAIL add_ctrl: got %h/%b want 10a/1", ex_ctrl, ex_valid); end
        checks++; if (ex_d1 !== 32'hA000_0001 || ex_d2 !== 32'hB000_0002 || ex_pc4 !== 32'h0000_1003) begin errors++; $display("FAIL add_data: got %h %h %h", ex_d1, ex_d2, ex_pc4); end
        drive(5'd4, 5'd5, 5'd6, 1'b1, 1'b0, C_ADD);
        tick();
        checks++; if (ex_ctrl !== 9'h0 || ex_valid !== 1'b0 || ex_rs !== 5'd4) begin errors++; $display("FAIL invalid_id: got ctrl %h valid %b rs %0d want 000/0/4", ex_ctrl, ex_valid, ex_rs); end
    endtask

    task automatic test_load_use();
        drive(5'd1, 5'd5, 5'd0, 1'b0, 1'b1, C_LW);
        tick();
        drive(5'd5, 5'd2, 5'd6, 1'b1, 1'b1, C_ADD);
        checks++; if (pc_write !== 1'b0 || ifid_write !== 1'b0) begin errors++; $display("FAIL lu_stall: got %b/%b want 0/0", pc_write, ifid_write); end
        tick();
        checks++; if (ex_ctrl !== 9'h0 || ex_valid !== 1'b0 || ex_rs !== 5'd0 || ex_rt !== 5'd0 || ex_rd !== 5'd0) begin errors++; $display("FAIL lu_bubble: got ctrl %h valid %b rs %0d rt %0d rd %0d", ex_ctrl, ex_valid, ex_rs, ex_rt, ex_rd); end
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt); end
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL lu_release: got %b want 1", pc_write); end
        tick();
        checks++; if (ex_rs !== 5'd5 || ex_rd !== 5'd6 || ex_ctrl !== C_ADD || ex_valid !== 1'b1) begin errors++; $display("FAIL lu_consumer: got rs %0d rd %0d ctrl %h valid %b", ex_rs, ex_rd, ex_ctrl, ex_valid); end
    endtask

    task automatic test_rs_only();
        drive(5'd1, 5'd5, 5'd0, 1'b0, 1'b1, C_LW);
        tick();
        drive(5'd5, 5'd5, 5'd7, 1'b0, 1'b1, C_ADDI);
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL rs_stall: got %b want 0", pc_write); end
        tick();
        checks++; if (stall_cnt !== 16'd2 || ex_ctrl !== 9'h0) begin errors++; $display("FAIL rs_bubble: got cnt %0d ctrl %h want 2/000", stall_cnt, ex_ctrl); end
        tick();
        drive(5'd1, 5'd5, 5'd0, 1'b0, 1'b1, C_LW);
        tick();
        drive(5'd2, 5'd5, 5'd7, 1'b0, 1'b1, C_ADDI);
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL rt_unused: got %b want 1", pc_write); end
        tick();
        checks++; if (ex_rs !== 5'd2 || ex_ctrl !== C_ADDI || stall_cnt !== 16'd2) begin errors++; $display("FAIL rt_unused_load: got rs %0d ctrl %h cnt %0d", ex_rs, ex_ctrl, stall_cnt); end
    endtask

    task automatic test_reg0();
        drive(5'd1, 5'd0, 5'd0, 1'b0, 1'b1, C_LW);
        tick();
        drive(5'd0, 5'd0, 5'd1, 1'b1, 1'b1, C_ADD);
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL reg0_pcwrite: got %b want 1", pc_write); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd1 || stall_cnt !== 16'd2) begin errors++; $display("FAIL reg0_load: got valid %b rd %0d cnt %0d", ex_valid, ex_rd, stall_cnt); end
    endtask

    task automatic test_flush();
        drive(5'd1, 5'd5, 5'd0, 1'b0, 1'b1, C_LW);
        tick();
        drive(5'd5, 5'd2, 5'd6, 1'b1, 1'b1, C_ADD);
        flush = 1'b1;
        #1;
        checks++; if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin errors++; $display("FAIL flush_pcwrite: got %b/%b want 1/1", pc_write, ifid_write); end
        tick();
        flush = 1'b0;
        checks++; if (ex_ctrl !== 9'h0 || ex_valid !== 1'b0 || ex_rs !== 5'd0 || ex_rd !== 5'd0) begin errors++; $display("FAIL flush_bubble: got ctrl %h valid %b rs %0d rd %0d", ex_ctrl, ex_valid, ex_rs, ex_rd); end
        checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd2) begin errors++; $display("FAIL flush_cnt: got %0d/%0d want 1/2", flush_cnt, stall_cnt); end
    endtask

    task automatic test_hold();
        drive(5'd1, 5'd5, 5'd0, 1'b0, 1'b1, C_LW);
        tick();
        drive(5'd5, 5'd2, 5'd6, 1'b1, 1'b1, C_ADD);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (pc_write !== 1'b0 || ifid_write !== 1'b0) begin errors++; $display("FAIL hold_pcwrite[%0d]: got %b/%b want 0/0", i, pc_write, ifid_write); end
            tick();
            checks++; if (ex_ctrl !== C_LW || ex_rt !== 5'd5 || ex_valid !== 1'b1 || stall_cnt !== 16'd2 || flush_cnt !== 16'd1) begin errors++; $display("FAIL hold_frozen[%0d]: got ctrl %h rt %0d valid %b cnt %0d/%0d", i, ex_ctrl, ex_rt, ex_valid, stall_cnt, flush_cnt); end
        end
        hold = 1'b0;
        #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL hold_release_stall: got %b want 0", pc_write); end
        tick();
        checks++; if (stall_cnt !== 16'd3 || ex_ctrl !== 9'h0) begin errors++; $display("FAIL hold_bubble: got cnt %0d ctrl %h want 3/000", stall_cnt, ex_ctrl); end
        tick();
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 6; i++) begin
            drive(5'd1, 5'd5, 5'd0, 1'b0, 1'b1, C_LW);
            tick();
            drive(5'd5, 5'd2, 5'd6, 1'b1, 1'b1, C_ADD);
            tick();
        end
        checks++; if (stall_cnt !== 16'd9) begin errors++; $display("FAIL sat_main_stall: got %0d want 9", stall_cnt); end
        checks++; if (s_stall_cnt !== 3'd7) begin errors++; $display("FAIL sat_stall: got %0d want 7", s_stall_cnt); end
        flush = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        flush = 1'b0;
        checks++; if (flush_cnt !== 16'd8) begin errors++; $display("FAIL sat_main_flush: got %0d want 8", flush_cnt); end
        checks++; if (s_flush_cnt !== 3'd7) begin errors++; $display("FAIL sat_flush: got %0d want 7", s_flush_cnt); end
    endtask

    task automatic test_reset_mid_stall();
        drive(5'd1, 5'd5, 5'd0, 1'b0, 1'b1, C_LW);
        tick();
        drive(5'd5, 5'd2, 5'd6, 1'b1, 1'b1, C_ADD);
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL mid_stall_pre: got %b want 0", pc_write); end
        reset = 1'b0;
        #1;
        checks++; if (ex_ctrl !== 9'h0 || ex_valid !== 1'b0 || ex_rt !== 5'd0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL mid_stall_reset: got ctrl %h valid %b rt %0d cnt %0d/%0d", ex_ctrl, ex_valid, ex_rt, stall_cnt, flush_cnt); end
        reset = 1'b1;
        #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL mid_stall_pcwrite: got %b want 1", pc_write); end
        tick();
        checks++; if (ex_ctrl !== C_ADD || ex_rs !== 5'd5) begin errors++; $display("FAIL mid_stall_resume: got ctrl %h rs %0d", ex_ctrl, ex_rs); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_load_use();
        test_rs_only();
        test_reg0();
        test_flush();
        test_hold();
        test_saturate();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register combined with load-use hazard detection for the 5-stage MIPS pipeline. It captures decoded operands, register numbers and control from ID, and inserts bubbles on load-use hazards and EX-resolved control-flow flushes. It drives the EX stage and supplies ID_EX_Rs/ID_EX_Rt to the downstream forwarding unit. It also keeps a saturating stall/flush performance count.

Parameters:
DATA_W, 32, operand / PC width
CNT_W, 16, width of stall and flush performance counters

Ports:
clk  input  1  pipeline clock
reset  input  1  asynchronous, active-low reset
hold  input  1  global freeze (memory wait); all state held
flush  input  1  branch/jump taken in EX; squash instruction entering ID/EX
IF_ID_Rs  input  5  rs field of instruction in ID
IF_ID_Rt  input  5  rt field of instruction in ID
IF_ID_Rd  input  5  rd field of instruction in ID
IF_ID_UsesRt  input  1  ID instruction reads rt as a source (R-type, store, beq/bne)
IF_ID_Valid  input  1  ID holds a real instruction
ID_Ctrl  input  9  {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, ALUOp[2:0]}
ID_Data1  input  DATA_W  register-file read data rs
ID_Data2  input  DATA_W  register-file read data rt
ID_Imm  input  DATA_W  sign/zero-extended immediate
ID_PC4  input  DATA_W  PC+4 of ID instruction
ID_EX_Rs, ID_EX_Rt, ID_EX_Rd  output  5 each  registered register numbers
ID_EX_Ctrl  output  9  registered control
ID_EX_Data1, ID_EX_Data2, ID_EX_Imm, ID_EX_PC4  output  DATA_W each  registered operands
ID_EX_Valid  output  1  EX holds a real instruction
PCWrite  output  1  0 = freeze PC (combinational)
IF_ID_Write  output  1  0 = freeze IF/ID (combinational)
stall_cnt  output  CNT_W  load-use stall cycles, saturating
flush_cnt  output  CNT_W  flush bubbles inserted, saturating

Behaviour:
- Reset (reset=0, async): all registered outputs 0, i.e. ID_EX_Valid=0, ID_EX_Ctrl=0 (bubble), counters 0.
- Hazard (combinational): lu = ID_EX_Valid & ID_EX_Ctrl.MemRead & (ID_EX_Rt!=0) & IF_ID_Valid & ((ID_EX_Rt==IF_ID_Rs) | (IF_ID_UsesRt & ID_EX_Rt==IF_ID_Rt)).
- stall = lu & ~flush & ~hold. PCWrite = IF_ID_Write = ~stall & ~hold.
- Per-edge priority: hold > flush > stall > load.
  - hold: every register and counter keeps its value.
  - flush: Ctrl<=0, Valid<=0, Rs/Rt/Rd<=0; data fields don't-care (implementation loads them); flush_cnt+1.
  - stall: same bubble as flush (Ctrl=0, Valid=0, Rs/Rt/Rd=0); stall_cnt+1.
  - load: all fields from ID inputs; Valid<=IF_ID_Valid; Ctrl<=IF_ID_Valid ? ID_Ctrl : 0.
- Latency: 1 cycle ID->EX. A load-use pair costs exactly one bubble: after the bubble, ID_EX_Ctrl.MemRead=0, so lu drops and the held consumer loads on the next edge. MEM->EX forwarding then supplies the value.
- Bubble Rs/Rt=0 guarantees that the forwarding unit never matches on a bubble.
- Register $0: a load targeting rt=0 never stalls.
- Flush with a simultaneous hazard: no stall, and PCWrite=1 because the wrong-path ID instruction is discarded.
- Counters saturate at all-ones and never wrap.
- Reset mid-stall: returns immediately to bubble state; PCWrite=1 once reset is released and no hazard exists.

Decomposition:
- Shared package pipeline_pkg: control-bundle bit positions (CTRL_REGWRITE … CTRL_ALUOP), CTRL_W=9, the BUBBLE constant (all-zero).
- One natural sub-module: hazard_detect (pure combinational lu/stall/PCWrite/IF_ID_Write).
- Counters and the register stay in id_ex_stage.

Test Plan:
- Reset release, then an ID add $3,$1,$2 (Valid=1, RegWrite=1) -> next cycle ID_EX_Rs=1, Rt=2, Rd=3, Ctrl matches input, Valid=1, PCWrite=1.
- lw $5,0($1) in EX, then add $6,$5,$2 in ID -> PCWrite=IF_ID_Write=0 for one cycle, then a bubble in ID/EX (Ctrl=0, Rs=Rt=0), stall_cnt=1; add loads on the following cycle.
- lw $5 in EX, then addi $7,$5,4 with IF_ID_Rt=5 and UsesRt=0 -> still stalls via Rs=5. With IF_ID_Rs=2 and Rt=5, UsesRt=0 -> no stall.
- lw $0 in EX, then add $1,$0,$0 in ID -> no stall, stall_cnt unchanged.
- flush=1 coinciding with a load-use hazard -> PCWrite=1, bubble inserted, flush_cnt+1, stall_cnt unchanged.
- hold=1 for 3 cycles during a hazard -> all outputs and counters frozen, PCWrite=0. Force stall_cnt to 0xFFFF and stall once more -> counter stays 0xFFFF.
